div_rem_unit: RTL and testbench

Iterative 32-bit integer divider for the RV32M DIV, DIVU, REM and REMU instructions. It sits beside the ALU in the execute path and is started by the control unit's EXECUTE state. It produces the single-cycle `div_rem_finnished` pulse that lets the control unit load the PC and leave EXECUTE. The result is held until the next divide starts, so writeback can sample it in the finish cycle.

---
 rtl/div_rem_unit.sv | 121 ++++++++++++
 tb/tb_div_rem_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/div_rem_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish early.
module div_rem_unit #(
   parameter logic [31:0] EXECUTE_STATE = 32'd1,
   parameter logic [31:0] OP_BASE       = 32'd14
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_state,
   input  logic [31:0] i_instruction,
   input  logic [31:0] i_rs1,
   input  logic [31:0] i_rs2,
   output logic [31:0] o_result,
   output logic        o_div_rem_finnished,
   output logic        o_busy
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 5;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state, state_next;

   logic [XLEN-1:0]  dividend, divisor, rem_acc, quot;
   logic [CNT_W-1:0] count;
   logic             op_rem, neg_q, neg_r;

   logic             in_exec_c, op_hit_c, start_c;
   logic [1:0]       in_op_c;
   logic             in_signed_c, in_rem_c;
   logic             div_zero_c, ovf_c, special_c;
   logic [XLEN-1:0]  special_result_c, rs1_abs_c, rs2_abs_c;
   logic [XLEN:0]    rem_shift_c, diff_c;
   logic             step_ok_c;
   logic [XLEN-1:0]  rem_step_c, quot_step_c, final_q_c, final_r_c;

   // Start decode and special-case detection from live operands
   always_comb begin
      in_exec_c   = (i_state == EXECUTE_STATE);
      op_hit_c    = (i_instruction >= OP_BASE) && (i_instruction <= OP_BASE + 32'd3);
      start_c     = in_exec_c && op_hit_c && (state == IDLE);
      in_op_c     = 2'(i_instruction - OP_BASE);
      in_signed_c = ~in_op_c[0];
      in_rem_c    = in_op_c[1];
      div_zero_c  = (i_rs2 == '0);
      ovf_c       = in_signed_c && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
      special_c   = div_zero_c || ovf_c;
      if (div_zero_c) special_result_c = in_rem_c ? i_rs1 : 32'hFFFF_FFFF;
      else            special_result_c = in_rem_c ? 32'h0 : 32'h8000_0000;
      rs1_abs_c   = (in_signed_c && i_rs1[XLEN-1]) ? (~i_rs1 + 32'd1) : i_rs1;
      rs2_abs_c   = (in_signed_c && i_rs2[XLEN-1]) ? (~i_rs2 + 32'd1) : i_rs2;
   end

   // One restoring-division step plus sign correction of the final step
   always_comb begin
      rem_shift_c = {rem_acc, dividend[XLEN-1]};
      diff_c      = rem_shift_c - {1'b0, divisor};
      step_ok_c   = ~diff_c[XLEN];
      rem_step_c  = step_ok_c ? diff_c[XLEN-1:0] : rem_shift_c[XLEN-1:0];
      quot_step_c = {quot[XLEN-2:0], step_ok_c};
      final_q_c   = neg_q ? (~quot_step_c + 32'd1) : quot_step_c;
      final_r_c   = neg_r ? (~rem_step_c + 32'd1) : rem_step_c;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start_c) state_next = special_c ? DONE : BUSY;
         BUSY: begin
            if (!in_exec_c)              state_next = IDLE;
            else if (count == LAST_ITER) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_result            <= '0;
         o_div_rem_finnished <= 1'b0;
         o_busy              <= 1'b0;
         dividend            <= '0;
         divisor             <= '0;
         rem_acc             <= '0;
         quot                <= '0;
         count               <= '0;
         op_rem              <= 1'b0;
         neg_q               <= 1'b0;
         neg_r               <= 1'b0;
      end else begin
         o_busy              <= (state_next != IDLE);
         o_div_rem_finnished <= (state_next == DONE);
         if (start_c) begin
            op_rem   <= in_rem_c;
            neg_q    <= in_signed_c && (i_rs1[XLEN-1] != i_rs2[XLEN-1]);
            neg_r    <= in_signed_c && i_rs1[XLEN-1];
            dividend <= rs1_abs_c;
            divisor  <= rs2_abs_c;
            rem_acc  <= '0;
            quot     <= '0;
            count    <= '0;
            if (special_c) o_result <= special_result_c;
         end else if (state == BUSY && in_exec_c) begin
            rem_acc  <= rem_step_c;
            quot     <= quot_step_c;
            dividend <= {dividend[XLEN-2:0], 1'b0};
            count    <= count + CNT_W'(1);
            if (count == LAST_ITER) o_result <= op_rem ? final_r_c : final_q_c;
         end
      end
   end

endmodule

// File: tb/tb_div_rem_unit.sv
// Directed bench for div_rem_unit: vector table plus reset/abort sequences.
module tb_div_rem_unit;

   localparam logic [31:0] EXEC  = 32'd1;
   localparam logic [31:0] C_DIV = 32'd14, C_DIVU = 32'd15, C_REM = 32'd16, C_REMU = 32'd17;

   logic        i_clk, i_rst_n;
   logic [31:0] i_state, i_instruction, i_rs1, i_rs2;
   logic [31:0] o_result;
   logic        o_div_rem_finnished, o_busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[15];

   div_rem_unit #(.EXECUTE_STATE(32'd1), .OP_BASE(32'd14)) dut (
      .i_clk               (i_clk),
      .i_rst_n             (i_rst_n),
      .i_state             (i_state),
      .i_instruction       (i_instruction),
      .i_rs1               (i_rs1),
      .i_rs2               (i_rs2),
      .o_result            (o_result),
      .o_div_rem_finnished (o_div_rem_finnished),
      .o_busy              (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge i_clk);
      #1;
   endtask

   // Start one op, scramble operands after the start edge, measure pulse latency
   task automatic run_op(input string nm, input logic [31:0] instr, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] exp, input int exp_lat);
      int lat, busy_cnt;
      bit got;
      logic [31:0] res;
      lat = 0; busy_cnt = 0; got = 0; res = '0;
      next_cycle();
      i_state = EXEC; i_instruction = instr; i_rs1 = rs1; i_rs2 = rs2;
      @(negedge i_clk);
      chk({nm, " no pulse at start"}, 32'(o_div_rem_finnished), 32'd0);
      while (!got && lat < 40) begin
         next_cycle();
         if (lat == 0) begin
            i_rs1 = $urandom; i_rs2 = $urandom; i_instruction = 32'd0;
         end
         lat++;
         @(negedge i_clk);
         if (o_busy) busy_cnt++;
         if (o_div_rem_finnished) begin
            got = 1; res = o_result;
         end
      end
      chk({nm, " pulse seen"}, 32'(got), 32'd1);
      chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
      chk({nm, " result"}, res, exp);
      chk({nm, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
      next_cycle();
      i_state = 32'd0;
      @(negedge i_clk);
      chk({nm, " idle after"}, {30'd0, o_busy, o_div_rem_finnished}, 32'd0);
      chk({nm, " result held"}, o_result, exp);
   endtask

   initial begin
      int pulses;
      vecs[0]  = '{C_DIVU, 32'd100,        32'd7,          32'd14,         33};
      vecs[1]  = '{C_REMU, 32'd100,        32'd7,          32'd2,          33};
      vecs[2]  = '{C_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33};
      vecs[3]  = '{C_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33};
      vecs[4]  = '{C_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  33};
      vecs[5]  = '{C_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          33};
      vecs[6]  = '{C_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
      vecs[7]  = '{C_REMU, 32'd5,          32'd0,          32'd5,          1};
      vecs[8]  = '{C_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
      vecs[9]  = '{C_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
      vecs[10] = '{C_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
      vecs[11] = '{C_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
      vecs[12] = '{C_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
      vecs[13] = '{C_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          33};
      vecs[14] = '{C_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  33};

      i_rst_n = 1'b0; i_state = '0; i_instruction = '0; i_rs1 = '0; i_rs2 = '0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk("reset result", o_result, 32'd0);
      chk("reset finish", 32'(o_div_rem_finnished), 32'd0);
      chk("reset busy", 32'(o_busy), 32'd0);
      next_cycle();
      i_rst_n = 1'b1;

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].instr, vecs[i].rs1, vecs[i].rs2,
                vecs[i].exp, vecs[i].lat);

      // Reset asserted in the tenth BUSY cycle
      next_cycle();
      i_state = EXEC; i_instruction = C_DIVU; i_rs1 = 32'd100; i_rs2 = 32'd7;
      repeat (10) next_cycle();
      @(negedge i_clk);
      chk("midreset busy before", 32'(o_busy), 32'd1);
      i_rst_n = 1'b0;
      next_cycle();
      i_rst_n = 1'b1; i_state = 32'd0;
      @(negedge i_clk);
      chk("midreset outputs", {o_result[29:0], o_busy, o_div_rem_finnished}, 32'd0);
      pulses = 0;
      repeat (40) begin
         @(negedge i_clk);
         if (o_div_rem_finnished || o_busy) pulses++;
      end
      chk("midreset no activity", 32'(pulses), 32'd0);
      run_op("after reset divu 9/3", C_DIVU, 32'd9, 32'd3, 32'd3, 33);

      // Abort by leaving EXECUTE in the fifth BUSY cycle
      run_op("pre-abort divu", C_DIVU, 32'd100, 32'd7, 32'd14, 33);
      next_cycle();
      i_state = EXEC; i_instruction = C_DIVU; i_rs1 = 32'd9; i_rs2 = 32'd3;
      repeat (5) next_cycle();
      i_state = 32'd0;
      next_cycle();
      @(negedge i_clk);
      chk("abort busy", 32'(o_busy), 32'd0);
      chk("abort result kept", o_result, 32'd14);
      pulses = 0;
      repeat (40) begin
         @(negedge i_clk);
         if (o_div_rem_finnished) pulses++;
      end
      chk("abort no pulse", 32'(pulses), 32'd0);
      run_op("restart div", C_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
